// File: rtl/tdm_demux.sv
// tdm_demux: steers a framed TDM word stream into per-channel output registers.
// Latency: a word accepted on edge N is visible on dout/dout_valid at edge N+1.
// Backpressure: none; every din_valid cycle is consumed or dropped at one word per cycle.
//
// Ports:
//   clk, rst (async, active-high)
//   din[W], din_valid, sof  : serial word stream, sof marks slot 0
//   dout[NCH*W]             : channel k in bits [k*W +: W], held between updates
//   dout_valid[NCH]         : per-channel update strobe
//   frame_done, sync_err    : one-cycle status pulses
//   locked                  : high while frame-aligned
//
// Build option TDM_DEMUX_FRAME_BUF_EN: when defined, words collect in a shadow
// register and dout is updated only with complete frames (all lanes at once).
module tdm_demux #(
    parameter int NCH = 4,
    parameter int W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [W-1:0]     din,
    input  logic             din_valid,
    input  logic             sof,
    output logic [NCH*W-1:0] dout,
    output logic [NCH-1:0]   dout_valid,
    output logic             frame_done,
    output logic             sync_err,
    output logic             locked
);

    localparam int SW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [SW-1:0] SLOT_ONE  = SW'(1);
    localparam logic [SW-1:0] SLOT_LAST = SW'(NCH - 1);

    typedef enum logic {
        HUNT = 1'b0,
        LOCK = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [SW-1:0]     slot_q, slot_d;
    logic [NCH*W-1:0]  dout_q, dout_d;
    logic [NCH-1:0]    dout_valid_q, dout_valid_d;
    logic              frame_done_q, frame_done_d;
    logic              sync_err_q, sync_err_d;

    // Decoded write request for the current word.
    logic              wr_en;
    logic [SW-1:0]     wr_ch;

`ifdef TDM_DEMUX_FRAME_BUF_EN
    logic [NCH*W-1:0]  shadow_q, shadow_d;
`endif

    // Framing FSM: decides whether the word is kept, which lane it targets,
    // and what the slot counter does next.
    always_comb begin
        state_d      = state_q;
        slot_d       = slot_q;
        frame_done_d = 1'b0;
        sync_err_d   = 1'b0;
        wr_en        = 1'b0;
        wr_ch        = '0;

        if (din_valid) begin
            unique case (state_q)
                HUNT: begin
                    if (sof) begin
                        wr_en   = 1'b1;
                        slot_d  = SLOT_ONE;
                        state_d = LOCK;
                    end
                end
                LOCK: begin
                    if (sof) begin
                        // A sof anywhere but slot 0 truncates the running
                        // frame; alignment restarts on this word.
                        sync_err_d = (slot_q != '0);
                        wr_en      = 1'b1;
                        slot_d     = SLOT_ONE;
                    end else if (slot_q == '0) begin
                        // Expected a frame start and did not get one.
                        sync_err_d = 1'b1;
                        state_d    = HUNT;
                    end else begin
                        wr_en = 1'b1;
                        wr_ch = slot_q;
                        if (slot_q == SLOT_LAST) begin
                            frame_done_d = 1'b1;
                            slot_d       = '0;
                        end else begin
                            slot_d = slot_q + SLOT_ONE;
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    // Output datapath.
    always_comb begin
        dout_d       = dout_q;
        dout_valid_d = '0;
`ifdef TDM_DEMUX_FRAME_BUF_EN
        shadow_d = shadow_q;
        if (wr_en) begin
            shadow_d[wr_ch*W +: W] = din;
        end
        // Publish the frame including the word arriving this cycle.
        if (frame_done_d) begin
            dout_d       = shadow_d;
            dout_valid_d = '1;
        end
`else
        if (wr_en) begin
            dout_d[wr_ch*W +: W] = din;
            dout_valid_d[wr_ch]  = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= HUNT;
            slot_q       <= '0;
            dout_q       <= '0;
            dout_valid_q <= '0;
            frame_done_q <= 1'b0;
            sync_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            slot_q       <= slot_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            frame_done_q <= frame_done_d;
            sync_err_q   <= sync_err_d;
        end
    end

`ifdef TDM_DEMUX_FRAME_BUF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_q <= '0;
        end else begin
            shadow_q <= shadow_d;
        end
    end
`endif

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign frame_done = frame_done_q;
    assign sync_err   = sync_err_q;
    assign locked     = (state_q == LOCK);

endmodule

// File: tb/tb_tdm_demux.sv
// Bench for tdm_demux: directed frame scenarios followed by random traffic,
// all outputs compared every cycle against a frame-level reference model.
module tb_tdm_demux;

    localparam int NCH = 4;
    localparam int W   = 8;

    logic             clk;
    logic             rst;
    logic [W-1:0]     din;
    logic             din_valid;
    logic             sof;
    logic [NCH*W-1:0] dout;
    logic [NCH-1:0]   dout_valid;
    logic             frame_done;
    logic             sync_err;
    logic             locked;

    int n_cmp;
    int n_err;

    tdm_demux #(.NCH(NCH), .W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .sof        (sof),
        .dout       (dout),
        .dout_valid (dout_valid),
        .frame_done (frame_done),
        .sync_err   (sync_err),
        .locked     (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: frame position as a plain integer, lanes as an array.
    bit             m_lock;
    int             m_pos;
    logic [W-1:0]   m_lane   [NCH];
    logic [W-1:0]   m_shadow [NCH];
    logic [NCH-1:0] m_dv;
    bit             m_fd;
    bit             m_se;

    function automatic logic [NCH*W-1:0] m_dout();
        logic [NCH*W-1:0] v;
        for (int k = 0; k < NCH; k++) v[k*W +: W] = m_lane[k];
        return v;
    endfunction

    task automatic model_reset();
        m_lock = 0;
        m_pos  = 0;
        m_dv   = '0;
        m_fd   = 0;
        m_se   = 0;
        for (int k = 0; k < NCH; k++) begin
            m_lane[k]   = '0;
            m_shadow[k] = '0;
        end
    endtask

    task automatic model_keep(input int ch, input logic [W-1:0] d);
`ifdef TDM_DEMUX_FRAME_BUF_EN
        m_shadow[ch] = d;
`else
        m_lane[ch] = d;
        m_dv[ch]   = 1'b1;
`endif
    endtask

    task automatic model_step(input logic v, input logic s, input logic [W-1:0] d);
        m_dv = '0;
        m_fd = 0;
        m_se = 0;
        if (v) begin
            if (!m_lock) begin
                if (s) begin
                    model_keep(0, d);
                    m_pos  = 1;
                    m_lock = 1;
                end
            end else if (s) begin
                m_se = (m_pos != 0);
                model_keep(0, d);
                m_pos = 1;
            end else if (m_pos == 0) begin
                m_se   = 1;
                m_lock = 0;
            end else begin
                model_keep(m_pos, d);
                if (m_pos == NCH - 1) m_fd = 1;
                m_pos = (m_pos + 1) % NCH;
            end
        end
`ifdef TDM_DEMUX_FRAME_BUF_EN
        if (m_fd) begin
            for (int k = 0; k < NCH; k++) m_lane[k] = m_shadow[k];
            m_dv = '1;
        end
`endif
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".dout"},       64'(dout),       64'(m_dout()));
        check({tag, ".dout_valid"}, 64'(dout_valid), 64'(m_dv));
        check({tag, ".frame_done"}, 64'(frame_done), 64'(m_fd));
        check({tag, ".sync_err"},   64'(sync_err),   64'(m_se));
        check({tag, ".locked"},     64'(locked),     64'(m_lock));
    endtask

    // One clock: drive at the falling edge, sample 1 time unit after the rising edge.
    task automatic step(input string tag, input logic v, input logic s, input logic [W-1:0] d);
        @(negedge clk);
        din_valid = v;
        sof       = s;
        din       = d;
        @(posedge clk);
        model_step(v, s, d);
        #1;
        check_all(tag);
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag, 1'b0, 1'b0, W'($urandom));
    endtask

    task automatic frame(input string tag, input logic [W-1:0] w0, input logic [W-1:0] w1,
                         input logic [W-1:0] w2, input logic [W-1:0] w3, input int gap);
        step(tag, 1'b1, 1'b1, w0);
        idle(tag, gap);
        step(tag, 1'b1, 1'b0, w1);
        idle(tag, gap);
        step(tag, 1'b1, 1'b0, w2);
        idle(tag, gap);
        step(tag, 1'b1, 1'b0, w3);
    endtask

    initial begin
        int pos;
        logic v, s;
        n_cmp     = 0;
        n_err     = 0;
        din       = '0;
        din_valid = 1'b0;
        sof       = 1'b0;
        rst       = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        rst = 1'b0;

        // Words without sof while hunting are dropped silently.
        step("hunt", 1'b1, 1'b0, 8'h5A);
        step("hunt", 1'b1, 1'b0, 8'hA5);
        step("hunt", 1'b1, 1'b0, 8'h3C);
        check("hunt_locked", 64'(locked), 64'd0);

        // Back-to-back frame.
        step("f1_s0", 1'b1, 1'b1, 8'h11);
`ifndef TDM_DEMUX_FRAME_BUF_EN
        check("f1_dv0", 64'(dout_valid), 64'h1);
`endif
        step("f1_s1", 1'b1, 1'b0, 8'h22);
        step("f1_s2", 1'b1, 1'b0, 8'h33);
        step("f1_s3", 1'b1, 1'b0, 8'h44);
        check("f1_fd", 64'(frame_done), 64'd1);
        check("f1_dout", 64'(dout), 64'h44332211);
        check("f1_locked", 64'(locked), 64'd1);
`ifdef TDM_DEMUX_FRAME_BUF_EN
        check("f1_dv_all", 64'(dout_valid), 64'hF);
`else
        check("f1_dv3", 64'(dout_valid), 64'h8);
`endif

        // Same frame with two idle cycles between words.
        frame("gap", 8'h11, 8'h22, 8'h33, 8'h44, 2);
        check("gap_dout", 64'(dout), 64'h44332211);
        check("gap_fd", 64'(frame_done), 64'd1);

        // Early sof truncates the running frame.
        step("early", 1'b1, 1'b1, 8'hA0);
        step("early", 1'b1, 1'b0, 8'hA1);
        step("early_sof", 1'b1, 1'b1, 8'hB0);
        check("early_se", 64'(sync_err), 64'd1);
        check("early_locked", 64'(locked), 64'd1);
        step("early", 1'b1, 1'b0, 8'hB1);
        step("early", 1'b1, 1'b0, 8'hB2);
        step("early", 1'b1, 1'b0, 8'hB3);
        check("early_fd", 64'(frame_done), 64'd1);
        check("early_dout", 64'(dout), 64'hB3B2B1B0);

        // Missing sof after a complete frame drops lock.
        step("miss", 1'b1, 1'b0, 8'hCC);
        check("miss_se", 64'(sync_err), 64'd1);
        check("miss_locked", 64'(locked), 64'd0);
        check("miss_dout", 64'(dout), 64'hB3B2B1B0);
        idle("miss_idle", 2);

        // Reset in the middle of a frame acts without a clock edge.
        step("rst_mid", 1'b1, 1'b1, 8'h01);
        step("rst_mid", 1'b1, 1'b0, 8'h02);
        step("rst_mid", 1'b1, 1'b0, 8'h03);
        @(negedge clk);
        din_valid = 1'b0;
        sof       = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all("rst_async");
        @(negedge clk);
        rst = 1'b0;
        idle("post_rst", 2);

        // Truncated frame then complete frame.
        frame("pre_trunc", 8'h11, 8'h22, 8'h33, 8'h44, 0);
        step("trunc", 1'b1, 1'b1, 8'h55);
        step("trunc", 1'b1, 1'b0, 8'h66);
        step("trunc", 1'b1, 1'b1, 8'h77);
`ifdef TDM_DEMUX_FRAME_BUF_EN
        check("trunc_dout", 64'(dout), 64'h44332211);
`endif

        // Random traffic: mostly well-formed framing with occasional sof errors.
        pos = 1;
        for (int i = 0; i < 600; i++) begin
            v = ($urandom_range(0, 9) < 7);
            s = (pos == 0) ^ ($urandom_range(0, 19) == 0);
            step("rand", v, s, W'($urandom));
            if (v) pos = s ? 1 : (pos + 1) % NCH;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
